data_sram_responder: RTL

// - Slave (responder) end of MemoryInterfaceSinglePort; serves the data-memory port driven by the memory stage.
// - Single-port word-organised data SRAM with:
//   - byte-lane steering from address[1:0];
//   - registered (1-cycle) reads;
//   - misaligned and out-of-range detection;
//   - optional post-reset zero-clear sweep.

---
 rtl/data_sram_responder_if.sv | 21 ++
 rtl/data_sram_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder_if.sv
// Single-port memory interface between the memory stage (master) and the data SRAM (slave).
interface data_sram_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic [3:0]            byte_enable;
  logic [31:0]           read_data;

  modport master (
    output enable, write_enable, address, write_data, byte_enable,
    input  read_data
  );

  modport slave (
    input  enable, write_enable, address, write_data, byte_enable,
    output read_data
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM responder: byte-lane steering, 1-cycle registered reads, error detection.
// Optional post-reset zero-clear sweep enabled by defining DSRAM_ZERO_INIT_EN.
module data_sram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  data_sram_responder_if.slave        sramport,
  output logic                        busy,
  output logic                        access_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic [7:0]       lanes;
  logic             misaligned;
  logic             out_of_range;
  logic             req_error;
  logic             is_access;
  logic             ready;
  logic             wr_req;
  logic             rd_req;
  logic             err_req;
  logic [2:0]       nbytes_d;

  assign word_idx     = sramport.address[IDX_W+1:2];
  assign offset       = sramport.address[1:0];
  assign lanes        = {4'b0000, sramport.byte_enable} << offset;
  assign misaligned   = |lanes[7:4];
  assign out_of_range = |sramport.address[ADDR_WIDTH-1:IDX_W+2];
  assign req_error    = misaligned | out_of_range;

  // Loads never raise enable, so any non-store cycle counts as an access.
  assign is_access = sramport.write_enable ? sramport.enable : 1'b1;
  assign wr_req    = ready && sramport.enable && sramport.write_enable && !req_error;
  assign rd_req    = ready && !sramport.write_enable && !req_error;
  assign err_req   = ready && is_access && req_error;

  assign nbytes_d = 3'(sramport.byte_enable[0]) + 3'(sramport.byte_enable[1])
                  + 3'(sramport.byte_enable[2]) + 3'(sramport.byte_enable[3]);

`ifdef DSRAM_ZERO_INIT_EN
  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_we;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        ready = 1'b1;
      end
    endcase
  end
`else
  assign busy  = 1'b0;
  assign ready = 1'b1;
`endif

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_lanes;

  always_comb begin
    mem_we    = wr_req;
    mem_widx  = word_idx;
    mem_wdata = sramport.write_data << {offset, 3'b000};
    mem_lanes = lanes[3:0];
`ifdef DSRAM_ZERO_INIT_EN
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_widx  = clr_idx_q;
      mem_wdata = '0;
      mem_lanes = 4'hF;
    end
`endif
  end

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register have no reset; a RAM is cleared by a sweep, not a reset net.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_lanes[k]) begin
          mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
    rdata_q <= mem[word_idx];
  end

  logic       valid_q;
  logic [1:0] offset_q;
  logic [2:0] nbytes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      offset_q     <= 2'b00;
      nbytes_q     <= 3'd0;
      access_error <= 1'b0;
    end else begin
      valid_q      <= rd_req;
      offset_q     <= offset;
      nbytes_q     <= nbytes_d;
      access_error <= err_req;
    end
  end

  // Right-align the loaded word and keep only as many bytes as the request asked for.
  logic [31:0] shifted;
  logic [31:0] byte_mask;

  always_comb begin
    shifted   = rdata_q >> {offset_q, 3'b000};
    byte_mask = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes_q) begin
        byte_mask[8*k +: 8] = 8'hFF;
      end
    end
    sramport.read_data = valid_q ? (shifted & byte_mask) : 32'h0;
  end

endmodule
